// File: rtl/count_enable_pkg.sv
// Shared definitions for the counter enable generator: enable-source modes and
// the button debounce state encoding.
package count_enable_pkg;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_FREE = 2'b01;
  localparam logic [1:0] MODE_STEP = 2'b10;
  localparam logic [1:0] MODE_HELD = 2'b11;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } db_state_e;

endpackage

// File: rtl/btn_debouncer.sv
// Two-flop synchroniser plus debounce FSM for a raw pushbutton; produces the
// clean level, a one-cycle press pulse, and their next-state values for the top.
module btn_debouncer
  import count_enable_pkg::*;
#(
  parameter int DB_CYCLES = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic btn_db_o,
  output logic press_o,
  output logic btn_db_next_o,
  output logic accept_o
);

  localparam int CNT_W = $clog2(DB_CYCLES + 1);
  // The transition into a WAIT state already counts as the first stable sample,
  // so a level is accepted on its DB_CYCLES-th consecutive synchronised sample.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES > 1 ? DB_CYCLES - 1 : 1);

  logic             s1_q, s2_q;
  db_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             btn_db_q, btn_db_d;
  logic             press_q, press_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    btn_db_d = btn_db_q;
    press_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (s2_q) begin
          state_d = PRESS_WAIT;
          cnt_d   = CNT_W'(1);
        end
      end
      PRESS_WAIT: begin
        if (!s2_q) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d  = PRESSED;
          btn_db_d = 1'b1;
          press_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PRESSED: begin
        if (!s2_q) begin
          state_d = RELEASE_WAIT;
          cnt_d   = CNT_W'(1);
        end
      end
      RELEASE_WAIT: begin
        if (s2_q) begin
          state_d = PRESSED;
        end else if (cnt_q == CNT_LAST) begin
          state_d  = IDLE;
          btn_db_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      state_q  <= IDLE;
      cnt_q    <= '0;
      btn_db_q <= 1'b0;
      press_q  <= 1'b0;
    end else begin
      s1_q     <= btn_i;
      s2_q     <= s1_q;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      btn_db_q <= btn_db_d;
      press_q  <= press_d;
    end
  end

  assign btn_db_o      = btn_db_q;
  assign press_o       = press_q;
  assign btn_db_next_o = btn_db_d;
  assign accept_o      = press_d;

endmodule

// File: rtl/count_enable_gen.sv
// Count-enable source for the downstream 4-bit counter: hold, programmable
// prescaler tick, debounced single-step, or run-while-held.
module count_enable_gen
  import count_enable_pkg::*;
#(
  parameter int PRESCALE_W = 8,
  parameter int DB_CYCLES  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            mode,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  btn,
  output logic                  t,
  output logic                  btn_db,
  output logic                  press
);

  logic [PRESCALE_W-1:0] pcnt_q, pcnt_d;
  logic                  tick;
  logic                  t_q, t_d;
  logic                  db_next;
  logic                  accept;

  btn_debouncer #(
    .DB_CYCLES(DB_CYCLES)
  ) u_debouncer (
    .clk_i        (clk),
    .rst_ni       (reset),
    .btn_i        (btn),
    .btn_db_o     (btn_db),
    .press_o      (press),
    .btn_db_next_o(db_next),
    .accept_o     (accept)
  );

  // Greater-or-equal compare so shrinking prescale mid-run ticks immediately.
  always_comb begin
    tick   = 1'b0;
    pcnt_d = '0;
    if (mode == MODE_FREE) begin
      if (pcnt_q >= prescale) begin
        tick = 1'b1;
      end else begin
        pcnt_d = pcnt_q + 1'b1;
      end
    end
  end

  // Step and held sources use next-state values so t aligns with press/btn_db.
  always_comb begin
    t_d = 1'b0;
    case (mode)
      MODE_HOLD: t_d = 1'b0;
      MODE_FREE: t_d = tick;
      MODE_STEP: t_d = accept;
      MODE_HELD: t_d = db_next;
      default:   t_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pcnt_q <= '0;
      t_q    <= 1'b0;
    end else begin
      pcnt_q <= pcnt_d;
      t_q    <= t_d;
    end
  end

  assign t = t_q;

endmodule

// File: tb/tb_count_enable_gen.sv
// Bench for count_enable_gen: run-length debounce and phase-counter reference
// model compared every cycle, directed scenarios, then randomized stimulus.
module tb_count_enable_gen;

  localparam int PW = 8;
  localparam int DB = 4;

  logic          clk;
  logic          reset;
  logic [1:0]    mode;
  logic [PW-1:0] prescale;
  logic          btn;
  logic          t, btn_db, press;

  int vectors;
  int miscompares;
  int t_cnt, pr_cnt;

  count_enable_gen #(.PRESCALE_W(PW), .DB_CYCLES(DB)) dut (
    .clk     (clk),
    .reset   (reset),
    .mode    (mode),
    .prescale(prescale),
    .btn     (btn),
    .t       (t),
    .btn_db  (btn_db),
    .press   (press)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: button seen two edges late; level flips after DB consecutive
  // samples disagreeing with it. Prescaler is a phase count since last tick.
  logic sh1, sh2, lvl;
  int   run, phase;
  logic exp_t, exp_db, exp_pr;
  logic m_acc, m_lvl_d, m_tick, m_t;
  int   m_run_d, m_phase_d;

  always_comb begin
    m_acc     = 1'b0;
    m_lvl_d   = lvl;
    m_run_d   = 0;
    if (sh2 != lvl) begin
      if (run + 1 >= DB) begin
        m_lvl_d = sh2;
        m_acc   = sh2;
      end else begin
        m_run_d = run + 1;
      end
    end
    m_tick    = 1'b0;
    m_phase_d = 0;
    if (mode == 2'b01) begin
      if (phase >= int'(prescale)) m_tick = 1'b1;
      else m_phase_d = phase + 1;
    end
    m_t = (mode == 2'b01) ? m_tick : (mode == 2'b10) ? m_acc : (mode == 2'b11) ? m_lvl_d : 1'b0;
  end

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      sh1 <= 1'b0; sh2 <= 1'b0; lvl <= 1'b0; run <= 0; phase <= 0;
      exp_t <= 1'b0; exp_db <= 1'b0; exp_pr <= 1'b0;
    end else begin
      sh1 <= btn; sh2 <= sh1; lvl <= m_lvl_d; run <= m_run_d; phase <= m_phase_d;
      exp_t <= m_t; exp_db <= m_lvl_d; exp_pr <= m_acc;
    end
  end

  always @(negedge clk) begin
    vectors = vectors + 1;
    if ({t, btn_db, press} !== {exp_t, exp_db, exp_pr}) begin
      miscompares = miscompares + 1;
      $display("FAIL cycle_compare @%0t: got t/db/press=%b%b%b want %b%b%b",
               $time, t, btn_db, press, exp_t, exp_db, exp_pr);
    end
    if (t === 1'b1) t_cnt = t_cnt + 1;
    if (press === 1'b1) pr_cnt = pr_cnt + 1;
  end

  task automatic check(input string name, input int act, input int exp);
    vectors = vectors + 1;
    if (act != exp) begin
      miscompares = miscompares + 1;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic clr();
    t_cnt  = 0;
    pr_cnt = 0;
  endtask

  int first, last, hold_left;

  initial begin
    vectors = 0; miscompares = 0; t_cnt = 0; pr_cnt = 0;
    reset = 1'b0; btn = 1'b1; mode = 2'b01; prescale = 8'd3;

    // Reset held with button pressed and free-run selected
    settle(6);
    check("rst_t", int'(t), 0);
    check("rst_btn_db", int'(btn_db), 0);
    check("rst_press", int'(press), 0);
    reset = 1'b1;
    repeat (5) @(posedge clk);
    #1 check("rel_db_early", int'(btn_db), 0);
    @(posedge clk);
    #1 check("rel_db_rise", int'(btn_db), 1);
    check("rel_press", int'(press), 1);

    // Free-run, prescale 3 then 0
    mode = 2'b00; btn = 1'b0;
    settle(12);
    mode = 2'b01; prescale = 8'd3;
    clr(); first = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (t === 1'b1 && first == 0) first = i;
    end
    #1 check("free3_count", t_cnt, 10);
    check("free3_first", first, 4);
    prescale = 8'd0; clr();
    settle(16);
    check("free0_count", t_cnt, 16);

    // Prescale shrink mid-run
    mode = 2'b00;
    settle(3);
    mode = 2'b01; prescale = 8'd20; clr();
    settle(10);
    check("shrink_before", t_cnt, 0);
    prescale = 8'd2;
    settle(1);
    check("shrink_tick", int'(t), 1);
    clr();
    settle(6);
    check("shrink_period3", t_cnt, 2);

    // Bounce in single-step mode
    mode = 2'b10; btn = 1'b0;
    settle(10);
    for (int i = 0; i < 4; i++) begin
      btn = (i % 2 == 0);
      settle(1);
    end
    btn = 1'b1; clr(); first = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (t === 1'b1 && first == 0) first = i;
    end
    #1 check("bounce_t_count", t_cnt, 1);
    check("bounce_t_edge", first, 6);
    check("bounce_press_count", pr_cnt, 1);

    // Press accepted in hold mode is not deferred into step mode
    mode = 2'b00; btn = 1'b0;
    settle(12);
    btn = 1'b1; clr();
    settle(8);
    mode = 2'b10;
    settle(10);
    check("gate_press_count", pr_cnt, 1);
    check("gate_t_count", t_cnt, 0);

    // Run-while-held
    mode = 2'b00; btn = 1'b0;
    settle(12);
    mode = 2'b11; btn = 1'b1; clr(); first = 0; last = 0;
    for (int i = 1; i <= 35; i++) begin
      @(negedge clk);
      if (t === 1'b1) begin
        if (first == 0) first = i;
        last = i;
      end
      if (i == 20) btn = 1'b0;
    end
    #1 check("held_count", t_cnt, 20);
    check("held_first", first, 6);
    check("held_last", last, 25);

    // Randomized run
    hold_left = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (hold_left == 0) begin
        btn = 1'($urandom);
        hold_left = $urandom_range(1, 9);
      end
      hold_left = hold_left - 1;
      if ($urandom_range(0, 15) == 0) mode = 2'($urandom);
      if ($urandom_range(0, 31) == 0) prescale = 8'($urandom_range(0, 7));
      if ($urandom_range(0, 299) == 0) begin
        #2 reset = 1'b0;
        @(negedge clk);
        #2 reset = 1'b1;
      end
    end

    settle(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
